// File: rtl/leb128_decoder.sv
// rtl/leb128_decoder.sv - streaming LEB128 immediate decoder (signed/unsigned, 32/64-bit)
module leb128_decoder #(
  parameter int MAX_BYTES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode_signed,
  input  logic        mode_64,
  output logic [63:0] out_value,
  output logic [3:0]  out_len,
  output logic        out_error,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  localparam logic [3:0] LAST64 = 4'(MAX_BYTES - 1);
  localparam logic [3:0] LAST32 = 4'd4;

  state_e      state_q, state_d;
  logic [63:0] acc_q, acc_d, val_q, val_d;
  logic [3:0]  cnt_q, cnt_d, len_q, len_d;
  logic        sgn_q, sgn_d, m64_q, m64_d, err_q, err_d, live_q, live_d;

  logic        take, sgn_eff, m64_eff, at_limit, final_ok, bad;
  logic [3:0]  idx;
  logic [6:0]  sh, ext_sh;
  logic [63:0] acc_new, ext_val;

  assign in_ready  = live_q && (state_q != DONE);
  assign take      = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_value = val_q;
  assign out_len   = len_q;
  assign out_error = err_q;

  // Modes come straight from the pins on the first byte, from the held copy afterwards.
  always_comb begin
    idx      = (state_q == IDLE) ? 4'd0 : cnt_q;
    sgn_eff  = (state_q == IDLE) ? mode_signed : sgn_q;
    m64_eff  = (state_q == IDLE) ? mode_64 : m64_q;
    sh       = 7'(idx) * 7'd7;
    ext_sh   = sh + 7'd7;
    acc_new  = ((state_q == IDLE) ? 64'd0 : acc_q) | ({57'd0, in_byte[6:0]} << sh);
    at_limit = m64_eff ? (idx == LAST64) : (idx == LAST32);
    case ({m64_eff, sgn_eff})
      2'b00:   final_ok = (in_byte[6:4] == 3'b000);
      2'b01:   final_ok = (in_byte[6:3] == 4'h0) || (in_byte[6:3] == 4'hF);
      2'b10:   final_ok = (in_byte[6:1] == 6'd0);
      default: final_ok = (in_byte[6:0] == 7'h00) || (in_byte[6:0] == 7'h7F);
    endcase
    bad     = in_byte[7] || (at_limit && !final_ok);
    ext_val = acc_new;
    // Shift amounts of 64 or more yield an empty mask, so a full-width value gets no extension.
    if (sgn_eff && in_byte[6]) ext_val = ext_val | ({64{1'b1}} << ext_sh);
    if (!m64_eff) ext_val[63:32] = sgn_eff ? {32{ext_val[31]}} : 32'd0;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    m64_d   = m64_q;
    val_d   = val_q;
    len_d   = len_q;
    err_d   = err_q;
    live_d  = 1'b1;
    case (state_q)
      IDLE, ACCUM: begin
        if (take) begin
          sgn_d = sgn_eff;
          m64_d = m64_eff;
          acc_d = acc_new;
          cnt_d = idx + 4'd1;
          if (in_byte[7] && !at_limit) begin
            state_d = ACCUM;
          end else begin
            state_d = DONE;
            err_d   = bad;
            val_d   = bad ? 64'd0 : ext_val;
            len_d   = idx + 4'd1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = 64'd0;
          cnt_d   = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= 64'd0;
      cnt_q   <= 4'd0;
      sgn_q   <= 1'b0;
      m64_q   <= 1'b0;
      val_q   <= 64'd0;
      len_q   <= 4'd0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      m64_q   <= m64_d;
      val_q   <= val_d;
      len_q   <= len_d;
      err_q   <= err_d;
      live_q  <= live_d;
    end
  end

endmodule

// File: tb/tb_leb128_decoder.sv
// tb/tb_leb128_decoder.sv - directed self-checking bench for leb128_decoder
module tb_leb128_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mode_signed = 1'b0;
  logic        mode_64 = 1'b0;
  logic [63:0] out_value;
  logic [3:0]  out_len;
  logic        out_error;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  leb128_decoder #(.MAX_BYTES(10)) dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .mode_signed(mode_signed), .mode_64(mode_64), .out_value(out_value), .out_len(out_len),
    .out_error(out_error), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Byte 0 of seq is in bits [7:0]; each byte waits a bounded time for in_ready.
  task automatic send_bytes(input int n, input logic [79:0] seq, input logic sgn, input logic m64);
    for (int i = 0; i < n; i++) begin
      in_byte = seq[8*i +: 8];
      in_valid = 1'b1;
      mode_signed = sgn;
      mode_64 = m64;
      for (int w = 0; w < 20 && !in_ready; w++) begin
        @(posedge clk); #1;
      end
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL send_ready: byte %0d in_ready=%b required 1", i, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_error, out_len, out_value} !== 71'd0) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%b v=%b e=%b len=%0d val=%h required all zero",
               in_ready, out_valid, out_error, out_len, out_value);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready: in_ready=%b required 0 before first edge", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_edge_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_unsigned32();
    send_bytes(2, 80'h8EE5, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL u32_no_early_valid: out_valid=%b required 0", out_valid);
    end
    send_bytes(1, 80'h26, 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_error, out_len, out_value} !== {1'b1, 1'b0, 4'd3, 64'h0000_0000_0009_8765}) begin
      failures++;
      $display("FAIL u32_e5_8e_26: v=%b e=%b len=%0d val=%h required v=1 e=0 len=3 val=0000000000098765",
               out_valid, out_error, out_len, out_value);
    end
    take_result();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL u32_release: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_signed32();
    send_bytes(1, 80'h7E, 1'b1, 1'b0);
    checks++;
    if ({out_valid, out_error, out_len, out_value} !== {1'b1, 1'b0, 4'd1, 64'hFFFF_FFFF_FFFF_FFFE}) begin
      failures++;
      $display("FAIL s32_7e: v=%b e=%b len=%0d val=%h required v=1 e=0 len=1 val=fffffffffffffffe",
               out_valid, out_error, out_len, out_value);
    end
    take_result();
    send_bytes(3, 80'h78BBC0, 1'b1, 1'b0);
    checks++;
    if ({out_valid, out_error, out_len, out_value} !== {1'b1, 1'b0, 4'd3, 64'hFFFF_FFFF_FFFE_1DC0}) begin
      failures++;
      $display("FAIL s32_c0_bb_78: v=%b e=%b len=%0d val=%h required v=1 e=0 len=3 val=fffffffffffe1dc0",
               out_valid, out_error, out_len, out_value);
    end
    take_result();
  endtask

  task automatic test_limit64();
    send_bytes(10, 80'h7FFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    checks++;
    if ({out_valid, out_error, out_len, out_value} !== {1'b1, 1'b0, 4'd10, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      failures++;
      $display("FAIL s64_all_ones: v=%b e=%b len=%0d val=%h required v=1 e=0 len=10 val=ffffffffffffffff",
               out_valid, out_error, out_len, out_value);
    end
    take_result();
    send_bytes(10, 80'h01FF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    checks++;
    if ({out_valid, out_error, out_len, out_value} !== {1'b1, 1'b1, 4'd10, 64'd0}) begin
      failures++;
      $display("FAIL s64_bad_last: v=%b e=%b len=%0d val=%h required v=1 e=1 len=10 val=0",
               out_valid, out_error, out_len, out_value);
    end
    take_result();
    send_bytes(10, 80'h0180_8080_8080_8080_8080, 1'b0, 1'b1);
    checks++;
    if ({out_valid, out_error, out_len, out_value} !== {1'b1, 1'b0, 4'd10, 64'h8000_0000_0000_0000}) begin
      failures++;
      $display("FAIL u64_top_bit: v=%b e=%b len=%0d val=%h required v=1 e=0 len=10 val=8000000000000000",
               out_valid, out_error, out_len, out_value);
    end
    take_result();
  endtask

  task automatic test_limit32();
    send_bytes(5, 80'h80_8080_8080, 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_error, out_len, out_value} !== {1'b1, 1'b1, 4'd5, 64'd0}) begin
      failures++;
      $display("FAIL u32_too_long: v=%b e=%b len=%0d val=%h required v=1 e=1 len=5 val=0",
               out_valid, out_error, out_len, out_value);
    end
    take_result();
    send_bytes(5, 80'h10_FFFF_FFFF, 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_error, out_len, out_value} !== {1'b1, 1'b1, 4'd5, 64'd0}) begin
      failures++;
      $display("FAIL u32_overflow: v=%b e=%b len=%0d val=%h required v=1 e=1 len=5 val=0",
               out_valid, out_error, out_len, out_value);
    end
    take_result();
    send_bytes(5, 80'h0F_FFFF_FFFF, 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_error, out_len, out_value} !== {1'b1, 1'b0, 4'd5, 64'h0000_0000_FFFF_FFFF}) begin
      failures++;
      $display("FAIL u32_max: v=%b e=%b len=%0d val=%h required v=1 e=0 len=5 val=00000000ffffffff",
               out_valid, out_error, out_len, out_value);
    end
    take_result();
  endtask

  task automatic test_mode_hold();
    send_bytes(1, 80'hC0, 1'b1, 1'b0);
    send_bytes(2, 80'h78BB, 1'b0, 1'b1);
    checks++;
    if ({out_valid, out_error, out_len, out_value} !== {1'b1, 1'b0, 4'd3, 64'hFFFF_FFFF_FFFE_1DC0}) begin
      failures++;
      $display("FAIL mode_hold: v=%b e=%b len=%0d val=%h required v=1 e=0 len=3 val=fffffffffffe1dc0",
               out_valid, out_error, out_len, out_value);
    end
    take_result();
  endtask

  task automatic test_accum_stall();
    send_bytes(1, 80'hE5, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL stall_wait: v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
    end
    send_bytes(2, 80'h268E, 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_error, out_len, out_value} !== {1'b1, 1'b0, 4'd3, 64'h98765}) begin
      failures++;
      $display("FAIL stall_result: v=%b e=%b len=%0d val=%h required v=1 e=0 len=3 val=98765",
               out_valid, out_error, out_len, out_value);
    end
    take_result();
  endtask

  task automatic test_backpressure();
    send_bytes(1, 80'h7E, 1'b1, 1'b0);
    in_byte = 8'h05;
    in_valid = 1'b1;
    mode_signed = 1'b0;
    mode_64 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({in_ready, out_valid, out_error, out_len, out_value} !==
          {1'b0, 1'b1, 1'b0, 4'd1, 64'hFFFF_FFFF_FFFF_FFFE}) begin
        failures++;
        $display("FAIL bp_hold_%0d: rdy=%b v=%b e=%b len=%0d val=%h required rdy=0 v=1 e=0 len=1 val=fffffffffffffffe",
                 c, in_ready, out_valid, out_error, out_len, out_value);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL bp_exit: v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_error, out_len, out_value} !== {1'b1, 1'b0, 4'd1, 64'h5}) begin
      failures++;
      $display("FAIL bp_next: v=%b e=%b len=%0d val=%h required v=1 e=0 len=1 val=5",
               out_valid, out_error, out_len, out_value);
    end
    take_result();
  endtask

  task automatic test_reset_mid();
    send_bytes(1, 80'hE5, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_error, out_len, out_value} !== 71'd0) begin
      failures++;
      $display("FAIL reset_accum: rdy=%b v=%b e=%b len=%0d val=%h required all zero",
               in_ready, out_valid, out_error, out_len, out_value);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send_bytes(1, 80'h26, 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_error, out_len, out_value} !== {1'b1, 1'b0, 4'd1, 64'h26}) begin
      failures++;
      $display("FAIL reset_fresh: v=%b e=%b len=%0d val=%h required v=1 e=0 len=1 val=26",
               out_valid, out_error, out_len, out_value);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_value, out_len} !== 69'd0) begin
      failures++;
      $display("FAIL reset_done: v=%b len=%0d val=%h required all zero", out_valid, out_len, out_value);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_ghost_%0d: out_valid=%b required 0", c, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned32();
    test_signed32();
    test_limit64();
    test_limit32();
    test_mode_hold();
    test_accum_stall();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
